// File: rtl/cg_timer_pkg.sv
// Shared types and constants for the cg_timer compare/control stage.
package cg_timer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_PENDING
    } state_t;

endpackage

// File: rtl/cg_timer_compare.sv
// Compare/control stage for the free-running counter: one-shot and periodic timeouts with level IRQ.
// Optional overrun detection is built only when CG_TIMER_OVERRUN_EN is defined.
module cg_timer_compare
    import cg_timer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [DATA_WIDTH-1:0] i_count,
    input  logic                  i_cfg_valid,
    output logic                  o_cfg_ready,
    input  logic [DATA_WIDTH-1:0] i_cfg_cmp,
    input  logic                  i_cfg_periodic,
    input  logic                  i_cancel,
    output logic                  o_prst,
    output logic                  o_stop,
    output logic [DATA_WIDTH-1:0] o_default,
    output logic                  o_irq,
    input  logic                  i_irq_ack,
    output logic                  o_overrun,
    output logic                  o_busy
);

    state_t                r_state;
    state_t                w_next_state;
    logic [DATA_WIDTH-1:0] r_cmp;
    logic                  r_periodic;
    logic                  r_irq;
    logic                  w_irq_next;
    logic                  w_match;
    logic                  w_accept;
`ifdef CG_TIMER_OVERRUN_EN
    logic                  r_overrun;
    logic                  w_set_ovr;
`endif

    assign w_match     = (i_count == r_cmp);
    assign o_cfg_ready = (r_state == ST_IDLE);
    assign w_accept    = i_cfg_valid & o_cfg_ready & ~i_cancel;
    assign o_default   = '0;
    assign o_irq       = r_irq;
    assign o_busy      = (r_state != ST_IDLE);

    always_comb begin
        w_next_state = r_state;
        w_irq_next   = r_irq;
        o_prst       = 1'b0;
        o_stop       = 1'b0;
`ifdef CG_TIMER_OVERRUN_EN
        w_set_ovr    = 1'b0;
`endif
        if (i_cancel) begin
            w_next_state = ST_IDLE;
            w_irq_next   = 1'b0;
            o_stop       = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        o_prst       = 1'b1;
                        w_next_state = ST_ARMED;
                    end else begin
                        o_stop = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (w_match) begin
                        w_irq_next   = 1'b1;
                        w_next_state = ST_PENDING;
                        o_prst       = r_periodic;
                        o_stop       = ~r_periodic;
                    end
                end
                ST_PENDING: begin
                    if (!r_periodic) begin
                        // one-shot holds the counter frozen at the match value until acknowledged
                        o_stop = 1'b1;
                        if (i_irq_ack && r_irq) begin
                            w_irq_next   = 1'b0;
                            w_next_state = ST_IDLE;
                        end
                    end else begin
                        o_prst = w_match;
                        if (i_irq_ack && r_irq && !w_match) begin
                            w_irq_next   = 1'b0;
                            w_next_state = ST_ARMED;
                        end
`ifdef CG_TIMER_OVERRUN_EN
                        w_set_ovr = w_match & ~i_irq_ack;
`endif
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state    <= ST_IDLE;
            r_irq      <= 1'b0;
            r_cmp      <= '0;
            r_periodic <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_irq   <= w_irq_next;
            if (w_accept) begin
                r_cmp      <= i_cfg_cmp;
                r_periodic <= i_cfg_periodic;
            end
        end
    end

`ifdef CG_TIMER_OVERRUN_EN
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_overrun <= 1'b0;
        end else if (w_accept) begin
            r_overrun <= 1'b0;
        end else if (w_set_ovr) begin
            r_overrun <= 1'b1;
        end
    end

    assign o_overrun = r_overrun;
`else
    assign o_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_cg_timer_compare.sv
// Self-checking bench for cg_timer_compare with a behavioural counter and system-level reference model.
module tb_cg_timer_compare;

    localparam int unsigned W = 32;
`ifdef CG_TIMER_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic         i_clk = 1'b0;
    logic         i_rstn;
    logic [W-1:0] r_count;
    logic         i_cfg_valid;
    logic         o_cfg_ready;
    logic [W-1:0] i_cfg_cmp;
    logic         i_cfg_periodic;
    logic         i_cancel;
    logic         o_prst;
    logic         o_stop;
    logic [W-1:0] o_default;
    logic         o_irq;
    logic         i_irq_ack;
    logic         o_overrun;
    logic         o_busy;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: timer running / interrupt outstanding / latched config / counter value
    bit           m_busy, m_irq, m_ovr, m_per;
    logic [W-1:0] m_cmp, m_count;

    always #5 i_clk = ~i_clk;

    cg_timer_compare #(.DATA_WIDTH(W)) dut (
        .i_clk          (i_clk),
        .i_rstn         (i_rstn),
        .i_count        (r_count),
        .i_cfg_valid    (i_cfg_valid),
        .o_cfg_ready    (o_cfg_ready),
        .i_cfg_cmp      (i_cfg_cmp),
        .i_cfg_periodic (i_cfg_periodic),
        .i_cancel       (i_cancel),
        .o_prst         (o_prst),
        .o_stop         (o_stop),
        .o_default      (o_default),
        .o_irq          (o_irq),
        .i_irq_ack      (i_irq_ack),
        .o_overrun      (o_overrun),
        .o_busy         (o_busy)
    );

    // stand-in for the CommonGoods free-running counter
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)     r_count <= '0;
        else if (o_prst) r_count <= o_default;
        else if (!o_stop) r_count <= r_count + 1'b1;
    end

    task automatic model_reset();
        m_busy = 0; m_irq = 0; m_ovr = 0; m_per = 0; m_cmp = '0; m_count = '0;
    endtask

    task automatic step(input bit v, input int unsigned c, input bit p, input bit can, input bit ack);
        bit acc, match, e_prst, e_stop;
        logic [5:0] exp_v, got_v;
        @(negedge i_clk);
        i_cfg_valid = v; i_cfg_cmp = c; i_cfg_periodic = p; i_cancel = can; i_irq_ack = ack;
        #1;
        acc   = v && !m_busy && !can;
        match = (m_count == m_cmp);
        if (can)              begin e_prst = 0;            e_stop = 1;            end
        else if (!m_busy)     begin e_prst = acc;          e_stop = !acc;         end
        else if (!m_irq)      begin e_prst = match && m_per; e_stop = match && !m_per; end
        else if (!m_per)      begin e_prst = 0;            e_stop = 1;            end
        else                  begin e_prst = match;        e_stop = 0;            end
        exp_v = {e_prst, e_stop, !m_busy, m_busy, m_irq, m_ovr};
        got_v = {o_prst, o_stop, o_cfg_ready, o_busy, o_irq, o_overrun};
        n_tests++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL outputs t=%0t got %b required %b (prst,stop,ready,busy,irq,ovr)", $time, got_v, exp_v);
        end
        n_tests++;
        if (r_count !== m_count) begin
            n_fail++;
            $display("FAIL count t=%0t got %0d required %0d", $time, r_count, m_count);
        end
        n_tests++;
        if (o_default !== '0) begin
            n_fail++;
            $display("FAIL default got %0h required 0", o_default);
        end
        if (e_prst) m_count = '0;
        else if (!e_stop) m_count = m_count + 1;
        if (can) begin
            m_busy = 0; m_irq = 0;
        end else if (!m_busy) begin
            if (acc) begin m_busy = 1; m_cmp = c; m_per = p; m_ovr = 0; end
        end else if (!m_irq) begin
            if (match) m_irq = 1;
        end else if (!m_per) begin
            if (ack) begin m_busy = 0; m_irq = 0; end
        end else begin
            if (ack && !match) m_irq = 0;
            if (match && !ack && OVR_EN) m_ovr = 1;
        end
    endtask

    task automatic test_reset();
        i_rstn = 0; i_cfg_valid = 0; i_cfg_cmp = '0; i_cfg_periodic = 0; i_cancel = 0; i_irq_ack = 0;
        #12;
        n_tests++;
        if ({o_stop, o_prst, o_irq, o_cfg_ready, o_overrun, o_busy} !== 6'b100100) begin
            n_fail++;
            $display("FAIL reset_state got %b required 100100", {o_stop, o_prst, o_irq, o_cfg_ready, o_overrun, o_busy});
        end
        @(negedge i_clk);
        i_rstn = 1;
        model_reset();
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
        n_tests++;
        if (r_count !== '0) begin n_fail++; $display("FAIL reset_hold_count got %0d required 0", r_count); end
    endtask

    task automatic test_oneshot();
        int first = -1;
        step(1, 5, 0, 0, 0);
        for (int i = 1; i <= 12; i++) begin
            step(0, 0, 0, 0, 0);
            if (o_irq && first < 0) first = i;
        end
        // step i observes the state after the (i-1)th edge following accept
        n_tests++;
        if (first - 1 !== 6) begin n_fail++; $display("FAIL oneshot_latency got %0d required 6", first - 1); end
        n_tests++;
        if (r_count !== 5) begin n_fail++; $display("FAIL oneshot_frozen got %0d required 5", r_count); end
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        n_tests++;
        if ({o_irq, o_cfg_ready} !== 2'b01) begin
            n_fail++; $display("FAIL oneshot_ack got irq,ready=%b required 01", {o_irq, o_cfg_ready});
        end
    endtask

    task automatic test_periodic_ack();
        int last_rise = -1;
        bit last_irq = 0;
        step(1, 3, 1, 0, 0);
        for (int i = 1; i <= 17; i++) begin
            step(0, 0, 0, 0, m_irq);
            n_tests++;
            if (r_count !== W'((i - 1) % 4)) begin
                n_fail++; $display("FAIL periodic_seq step %0d got %0d required %0d", i, r_count, (i - 1) % 4);
            end
            if (o_irq && !last_irq) begin
                if (last_rise >= 0) begin
                    n_tests++;
                    if (i - last_rise !== 4) begin
                        n_fail++; $display("FAIL periodic_period got %0d required 4", i - last_rise);
                    end
                end
                last_rise = i;
            end
            last_irq = o_irq;
        end
        n_tests++;
        if (o_overrun !== 1'b0) begin n_fail++; $display("FAIL periodic_no_overrun got %b required 0", o_overrun); end
        step(0, 0, 0, 1, 0);
    endtask

    task automatic test_overrun();
        step(1, 2, 1, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 0, 0, 0);
            if (i == 5) begin
                n_tests++;
                if (o_overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_early got %b required 0", o_overrun); end
            end
        end
        n_tests++;
        if (o_overrun !== OVR_EN) begin n_fail++; $display("FAIL overrun_set got %b required %b", o_overrun, OVR_EN); end
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        n_tests++;
        if ({o_irq, o_overrun} !== {1'b0, OVR_EN}) begin
            n_fail++; $display("FAIL overrun_retained got %b required %b", {o_irq, o_overrun}, {1'b0, OVR_EN});
        end
    endtask

    task automatic test_cmp0_ack_held();
        step(1, 0, 1, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            step(0, 0, 0, 0, 1);
            if (i >= 2) begin
                n_tests++;
                if ({o_irq, o_overrun} !== 2'b10) begin
                    n_fail++; $display("FAIL cmp0_irq step %0d got %b required 10", i, {o_irq, o_overrun});
                end
            end
        end
        step(0, 0, 0, 1, 0);
    endtask

    task automatic test_cancel();
        logic [W-1:0] held;
        step(1, 100, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        held = r_count;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        n_tests++;
        if ({o_busy, o_irq, o_cfg_ready} !== 3'b001 || r_count !== held) begin
            n_fail++; $display("FAIL cancel_armed got busy,irq,ready=%b count %0d required 001 count %0d",
                               {o_busy, o_irq, o_cfg_ready}, r_count, held);
        end
        step(1, 4, 0, 1, 0);
        held = r_count;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        n_tests++;
        if (o_busy !== 1'b0 || r_count !== held) begin
            n_fail++; $display("FAIL cancel_vs_accept got busy %b count %0d required 0 count %0d", o_busy, r_count, held);
        end
    endtask

    task automatic test_async_reset();
        step(1, 5, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        @(negedge i_clk);
        #2 i_rstn = 0;
        #1;
        n_tests++;
        if ({o_busy, o_irq, o_stop, o_prst} !== 4'b0010 || r_count !== '0) begin
            n_fail++; $display("FAIL async_reset got busy,irq,stop,prst=%b count %0d required 0010 count 0",
                               {o_busy, o_irq, o_stop, o_prst}, r_count);
        end
        model_reset();
        #1 i_rstn = 1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 5) == 0, $urandom_range(0, 7), $urandom % 2,
                 ($urandom % 40) == 0, ($urandom % 3) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic_ack();
        test_overrun();
        test_cmp0_ack_held();
        test_cancel();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
